// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
// Scheduler state encoding, tag byte field widths, default busy timeout.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TAG,
      S_LOAD,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } tx_state_t;

   localparam int TAG_PFX_W        = 5;
   localparam int TAG_ID_W         = 3;
   localparam int BUSY_TIMEOUT_DEF = 64;

   // Tag byte: prefix high bits, requester index low bits.
   function automatic logic [7:0] make_tag(
      input logic [7:0]          pfx,
      input logic [TAG_ID_W-1:0] id
   );
      return {pfx[7 -: TAG_PFX_W], id};
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick.
// Ports: req (request vector), ptr (first index to try) -> gnt (one-hot), idx, any.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] gnt,
   output logic [2:0]   idx,
   output logic         any
);

   logic [N-1:0] sh;
   logic [2:0]   pi;
   int           p;

   // Scan N slots starting at ptr, wrapping at N-1.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sh  = '0;
      pi  = '0;
      p   = 0;
      for (int i = 0; i < N; i++) begin
         p = int'(ptr) + i;
         if (p >= N)
            p = p - N;
         pi = 3'(p);
         sh = req >> pi;
         if (!any && sh[0]) begin
            any = 1'b1;
            idx = pi;
            gnt = N'(1) << pi;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among NUM_REQ byte streams.
// Ports: req_valid/req_data/req_last/req_ready (requesters), tx_start/tx_data/
// tx_busy (transmitter), grant_id, active, err_timeout/err_clr (status).
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int         NUM_REQ      = 4,
   parameter int         PACKET_MODE  = 1,
   parameter int         TAG_EN       = 0,
   parameter logic [7:0] TAG_PREFIX   = 8'hA0,
   parameter int         BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [2:0]           grant_id,
   output logic                 active,
   output logic                 err_timeout,
   input  logic                 err_clr
);

   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   tx_state_t          state;
   logic [2:0]         rr_ptr;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] gnt_q;
   logic               last_q;
   logic               tag_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [2:0]         arb_idx;
   logic               arb_any;
   logic [7:0]         g_data;
   logic               g_valid;
   logic               g_last;
   logic [2:0]         nxt_ptr;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      g_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt_q[i])
            g_data = req_data[8*i +: 8];
   end

   assign g_valid   = |(gnt_q & req_valid);
   assign g_last    = |(gnt_q & req_last);
   assign req_ready = (state == S_LOAD) ? (gnt_q & req_valid) : '0;
   assign active    = (state != S_IDLE);
   assign nxt_ptr   = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0
                                                    : grant_id + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         cnt         <= '0;
         gnt_q       <= '0;
         last_q      <= 1'b0;
         tag_q       <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         err_timeout <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         // A timeout below overrides this clear.
         if (err_clr)
            err_timeout <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (arb_any) begin
                  grant_id <= arb_idx;
                  gnt_q    <= arb_gnt;
                  state    <= (TAG_EN != 0) ? S_TAG : S_LOAD;
               end
            end
            S_TAG: begin
               tx_data  <= make_tag(TAG_PREFIX, grant_id);
               tx_start <= 1'b1;
               tag_q    <= 1'b1;
               cnt      <= '0;
               state    <= S_WAIT_BUSY;
            end
            S_LOAD: begin
               // Grant is held even while the owner stalls.
               if (g_valid) begin
                  tx_data  <= g_data;
                  tx_start <= 1'b1;
                  tag_q    <= 1'b0;
                  last_q   <= g_last || (PACKET_MODE == 0);
                  cnt      <= '0;
                  state    <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  cnt   <= '0;
                  state <= S_WAIT_DONE;
               end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  rr_ptr      <= nxt_ptr;
                  cnt         <= '0;
                  state       <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (tag_q) begin
                     tag_q <= 1'b0;
                     state <= S_LOAD;
                  end else if (last_q) begin
                     rr_ptr <= nxt_ptr;
                     state  <= S_IDLE;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: three scheduler configurations driven from shared
// packet rounds and checked against a queue-based arbitration model.
module tb_uart_tx_scheduler;

   localparam int N  = 4;
   localparam int NC = 3;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err_clr = 1'b0;

   always #5 clk = ~clk;

   logic [N-1:0] rdy  [NC];
   logic         ts   [NC];
   logic [7:0]   td   [NC];
   logic         bsy  [NC];
   logic [2:0]   gid  [NC];
   logic         act  [NC];
   logic         err  [NC];

   logic [8:0] rq   [NC][N][$];
   logic [7:0] expq [NC][$];
   logic [8:0] pk   [N][$];
   int         busy_dly [NC];
   int         busy_len [NC];
   bit         dead     [NC];
   int         mptr     [NC];

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   for (genvar c = 0; c < NC; c++) begin : g_dut
      localparam int PM = (c == 1) ? 0 : 1;
      localparam int TG = (c == 2) ? 1 : 0;

      logic [N-1:0]   l_rv;
      logic [N-1:0]   l_rl;
      logic [8*N-1:0] l_rd;
      logic           l_busy;
      logic [N-1:0]   took;
      int             tmr;
      int             blen;
      logic           prev_ts;

      uart_tx_scheduler #(
         .NUM_REQ(N), .PACKET_MODE(PM), .TAG_EN(TG),
         .TAG_PREFIX(8'hA0), .BUSY_TIMEOUT(TO)
      ) dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(l_rv), .req_data(l_rd), .req_last(l_rl),
         .req_ready(rdy[c]),
         .tx_start(ts[c]), .tx_data(td[c]), .tx_busy(l_busy),
         .grant_id(gid[c]), .active(act[c]),
         .err_timeout(err[c]), .err_clr(err_clr)
      );

      assign bsy[c] = l_busy;

      // Requesters: present queue heads, pop after an accepted cycle.
      always @(negedge clk) begin
         if (!rst_n)
            took = '0;
         for (int i = 0; i < N; i++)
            if (took[i] && rq[c][i].size() > 0)
               void'(rq[c][i].pop_front());
         for (int i = 0; i < N; i++) begin
            if (rq[c][i].size() > 0) begin
               l_rv[i]         = 1'b1;
               l_rd[8*i +: 8]  = rq[c][i][0][7:0];
               l_rl[i]         = rq[c][i][0][8];
            end else begin
               l_rv[i]         = 1'b0;
               l_rd[8*i +: 8]  = 8'h00;
               l_rl[i]         = 1'b0;
            end
         end
         #1;
         took = rst_n ? rdy[c] : '0;
      end

      // Transmitter: busy rises busy_dly cycles after a start, lasts busy_len.
      always @(negedge clk) begin
         if (!rst_n) begin
            l_busy = 1'b0;
            tmr    = 0;
            blen   = 0;
         end else begin
            if (blen > 0) begin
               blen--;
               if (blen == 0)
                  l_busy = 1'b0;
            end else if (tmr > 0) begin
               tmr--;
               if (tmr == 0) begin
                  l_busy = 1'b1;
                  blen   = busy_len[c];
               end
            end
            if (ts[c] && !dead[c]) begin
               if (busy_dly[c] == 0) begin
                  l_busy = 1'b1;
                  blen   = busy_len[c];
               end else begin
                  tmr = busy_dly[c];
               end
            end
         end
      end

      // Byte stream and handshake monitor.
      always @(negedge clk) begin
         #2;
         if (rst_n) begin
            if (ts[c]) begin
               check("start_one_cycle", 32'(prev_ts), 0);
               if (expq[c].size() == 0)
                  check("tx_unexpected", 32'(td[c]), 32'hFFFF_FFFF);
               else
                  check("tx_byte", 32'(td[c]), 32'(expq[c].pop_front()));
            end
            if (rdy[c] != '0)
               check("ready_onehot", 32'($onehot(rdy[c])), 1);
            prev_ts = ts[c];
         end else begin
            prev_ts = 1'b0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int c = 0; c < NC; c++) begin
         expq[c].delete();
         mptr[c] = 0;
         for (int i = 0; i < N; i++)
            rq[c][i].delete();
      end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Round-robin over requesters with pending bytes: one packet per grant
   // (one byte when packet mode is off), tag byte first when tagging.
   task automatic load_round();
      for (int c = 0; c < NC; c++) begin
         int pos [N];
         int p;
         int g;
         logic [8:0] b;
         p = mptr[c];
         for (int i = 0; i < N; i++)
            pos[i] = 0;
         forever begin
            g = -1;
            for (int k = 0; k < N; k++)
               if (g < 0 && pos[(p + k) % N] < pk[(p + k) % N].size())
                  g = (p + k) % N;
            if (g < 0)
               break;
            if (c == 2)
               expq[c].push_back({5'b10100, 3'(g)});
            while (pos[g] < pk[g].size()) begin
               b = pk[g][pos[g]];
               pos[g]++;
               expq[c].push_back(b[7:0]);
               if (c == 1 || b[8])
                  break;
            end
            p = (g + 1) % N;
         end
         mptr[c] = p;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < pk[i].size(); j++)
               rq[c][i].push_back(pk[i][j]);
      end
      for (int i = 0; i < N; i++)
         pk[i].delete();
   endtask

   task automatic wait_idle(input string tag);
      int t;
      bit pend;
      t = 0;
      do begin
         step();
         t++;
         pend = 1'b0;
         for (int c = 0; c < NC; c++) begin
            if (act[c] || bsy[c] || expq[c].size() != 0)
               pend = 1'b1;
            for (int i = 0; i < N; i++)
               if (rq[c][i].size() != 0)
                  pend = 1'b1;
         end
      end while (pend && t < 3000);
      check(tag, 32'(pend), 0);
   endtask

   task automatic wait_busy(input int c, input logic lvl, input string tag);
      int t;
      t = 0;
      while (bsy[c] !== lvl && t < 200) begin
         step();
         t++;
      end
      check(tag, 32'(bsy[c]), 32'(lvl));
   endtask

   task automatic wait_start(input int c, input string tag);
      int t;
      t = 0;
      while (ts[c] !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      check(tag, 32'(ts[c]), 1);
   endtask

   initial begin
      int np;
      int nb;
      int tot;
      for (int c = 0; c < NC; c++) begin
         busy_dly[c] = 2;
         busy_len[c] = 10;
         dead[c]     = 1'b0;
         mptr[c]     = 0;
      end

      // Reset values.
      step();
      step();
      for (int c = 0; c < NC; c++) begin
         check("rst_start", 32'(ts[c]), 0);
         check("rst_data", 32'(td[c]), 0);
         check("rst_ready", 32'(rdy[c]), 0);
         check("rst_grant", 32'(gid[c]), 0);
         check("rst_active", 32'(act[c]), 0);
         check("rst_err", 32'(err[c]), 0);
      end
      rst_n = 1'b1;
      step();

      // Single byte latency on the untagged packet-mode instance.
      rq[0][0].push_back(9'h155);
      expq[0].push_back(8'h55);
      step();
      check("lat0_ready", 32'(rdy[0]), 0);
      check("lat0_active", 32'(act[0]), 0);
      step();
      check("lat1_ready", 32'(rdy[0]), 4'b0001);
      check("lat1_active", 32'(act[0]), 1);
      check("lat1_start", 32'(ts[0]), 0);
      step();
      check("lat2_start", 32'(ts[0]), 1);
      check("lat2_data", 32'(td[0]), 8'h55);
      check("lat2_ready", 32'(rdy[0]), 0);
      step();
      check("lat3_start", 32'(ts[0]), 0);
      wait_busy(0, 1'b1, "lat_busy_rise");
      wait_busy(0, 1'b0, "lat_busy_fall");
      check("lat_active_at_fall", 32'(act[0]), 1);
      check("lat_data_held", 32'(td[0]), 8'h55);
      step();
      check("lat_active_after", 32'(act[0]), 0);

      // Round robin: 10..13 then req0's second packet.
      do_reset();
      pk[0].push_back(9'h110);
      pk[0].push_back(9'h120);
      pk[1].push_back(9'h111);
      pk[2].push_back(9'h112);
      pk[3].push_back(9'h113);
      load_round();
      wait_idle("rr_done");

      // Packet hold versus byte interleave.
      pk[1].push_back(9'h0A1);
      pk[1].push_back(9'h0A2);
      pk[1].push_back(9'h1A3);
      pk[2].push_back(9'h1B2);
      load_round();
      wait_idle("hold_done");

      // Tagged packet from req3.
      pk[3].push_back(9'h17E);
      load_round();
      wait_idle("tag_done");

      // Busy timeout, then the next requester is granted.
      do_reset();
      dead[0] = 1'b1;
      rq[0][0].push_back(9'h15A);
      rq[0][1].push_back(9'h15B);
      expq[0].push_back(8'h5A);
      expq[0].push_back(8'h5B);
      wait_start(0, "to_start");
      repeat (63) step();
      check("to_err_before", 32'(err[0]), 0);
      check("to_active_before", 32'(act[0]), 1);
      step();
      check("to_err_set", 32'(err[0]), 1);
      check("to_active_idle", 32'(act[0]), 0);
      dead[0] = 1'b0;
      step();
      check("to_next_grant", 32'(gid[0]), 1);
      check("to_next_ready", 32'(rdy[0]), 4'b0010);
      wait_idle("to_next_done");
      check("to_err_sticky", 32'(err[0]), 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_err_clr", 32'(err[0]), 0);

      // Clear coinciding with a fresh timeout: set wins.
      dead[0] = 1'b1;
      rq[0][2].push_back(9'h15C);
      expq[0].push_back(8'h5C);
      wait_start(0, "tc_start");
      repeat (63) step();
      check("tc_err_before", 32'(err[0]), 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("tc_set_wins", 32'(err[0]), 1);
      dead[0] = 1'b0;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("tc_err_clr", 32'(err[0]), 0);
      wait_idle("tc_done");

      // Asynchronous reset in the middle of a packet.
      pk[0].push_back(9'h031);
      pk[0].push_back(9'h132);
      load_round();
      wait_busy(0, 1'b1, "ar_busy");
      step();
      step();
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_start", 32'(ts[0]), 0);
      check("ar_data", 32'(td[0]), 0);
      check("ar_ready", 32'(rdy[0]), 0);
      check("ar_grant", 32'(gid[0]), 0);
      check("ar_active", 32'(act[0]), 0);
      check("ar_err", 32'(err[0]), 0);
      do_reset();
      pk[2].push_back(9'h1C5);
      load_round();
      wait_idle("ar_after_done");
      check("ar_after_grant", 32'(gid[0]), 2);

      // Random packet rounds with random transmitter timing.
      for (int r = 0; r < 25; r++) begin
         for (int c = 0; c < NC; c++) begin
            busy_dly[c] = $urandom_range(0, 4);
            busy_len[c] = $urandom_range(1, 6);
         end
         tot = 0;
         for (int i = 0; i < N; i++) begin
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
               nb = $urandom_range(1, 3);
               for (int j = 0; j < nb; j++)
                  pk[i].push_back({(j == nb - 1), 8'($urandom)});
               tot++;
            end
         end
         if (tot == 0)
            pk[$urandom_range(0, N - 1)].push_back({1'b1, 8'($urandom)});
         load_round();
         wait_idle("rnd_done");
         for (int c = 0; c < NC; c++)
            check("rnd_no_err", 32'(err[c]), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter among NUM_REQ byte-stream requesters (debounced button, switch bank, loopback echo, status reporter). It arbitrates round-robin at packet granularity and can prefix each packet with a source tag byte. It sequences the transmitter with a one-cycle start pulse and tracks its busy line. It sits between the requesters and the transmitter inside the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PACKET_MODE, 1, 1 = hold grant until req_last byte; 0 = re-arbitrate after every byte
TAG_EN, 0, 1 = send tag byte {TAG_PREFIX[7:3], grant_id[2:0]} before each packet
TAG_PREFIX, 8'hA0, upper 5 bits of tag byte
BUSY_TIMEOUT, 64, max cycles from tx_start to tx_busy rising

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
req_last  in  NUM_REQ  byte is last of packet (ignored if PACKET_MODE=0)
req_ready  out  NUM_REQ  byte accepted this cycle (one-hot or zero)
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmit, stable from tx_start until tx_busy falls
tx_busy  in  1  transmitter busy
grant_id  out  3  current/last granted requester
active  out  1  high whenever state != IDLE
err_timeout  out  1  sticky: tx_busy failed to rise within BUSY_TIMEOUT
err_clr  in  1  clears err_timeout

Behaviour:
- One clock; reset is asynchronous and active-low. Reset: state IDLE, tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, err_timeout=0, rr pointer=0, timeout counter=0.
- States: IDLE, TAG, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req_valid, grant first set bit at or after rr pointer (wrapping); register grant_id; go to TAG if TAG_EN else LOAD. No valid: stay.
- TAG: at edge, tx_data<=tag, tx_start<=1, mark byte as tag, go to WAIT_BUSY.
- LOAD: req_ready[grant_id]=req_valid[grant_id] (combinational). On accept edge: tx_data<=byte, tx_start<=1, latch last = req_last or !PACKET_MODE, go to WAIT_BUSY. If the granted requester drops valid, hold in LOAD with grant kept; other requesters are not served.
- tx_start is high exactly one cycle (first cycle of WAIT_BUSY).
- Latency, TAG_EN=0: req_valid first high in cycle 0 -> LOAD cycle 1 (req_ready high) -> tx_start high cycle 2.
- WAIT_BUSY: counter increments from 0. tx_busy=1 -> WAIT_DONE, counter cleared. Counter reaches BUSY_TIMEOUT-1 with tx_busy=0 -> err_timeout<=1, abort packet, rr pointer<=grant_id+1 mod NUM_REQ, go to IDLE.
- WAIT_DONE: wait for tx_busy=0. Then tag byte -> LOAD; last -> IDLE with rr pointer<=grant_id+1 mod NUM_REQ; otherwise -> LOAD (same grant).
- tx_busy already high on entry to WAIT_BUSY counts as risen.
- err_clr and a new timeout in the same cycle: set wins.
- Reset mid-transfer: immediate return to reset values; the partially sent packet is lost.
- NUM_REQ not a power of two: pointer wraps at NUM_REQ-1 to 0.

Decomposition:
- Shared package uart_pkg: state enum, tag-width constants, default BUSY_TIMEOUT.
- Sub-module rr_arbiter: combinational pointer-based priority pick (req vector, pointer -> one-hot grant, index, any). The FSM, counter and datapath stay in uart_tx_scheduler.

Test Plan:
- Single byte: NUM_REQ=4, TAG_EN=0; req0 sends 8'h55 with last=1; model busy rises 2 cycles after start and lasts 10 cycles -> req_ready[0] high cycle 1, tx_start high cycle 2 with tx_data=8'h55, active low again the cycle after busy falls.
- Round-robin: req0..req3 all valid with 1-byte packets 8'h10..8'h13 -> transmit order 10,11,12,13; req0 re-asserted afterwards is served after req3.
- Packet hold: req1 sends 3 bytes A1,A2,A3 (last on A3) while req2 is valid -> A1,A2,A3 go out before any req2 byte. With PACKET_MODE=0, order interleaves A1,req2 byte,A2.
- Tag: TAG_EN=1; req3 sends 8'h7E with last=1 -> tx_data sequence 8'hA3 then 8'h7E, each with its own tx_start pulse.
- Timeout: tx_busy tied 0, BUSY_TIMEOUT=64 -> err_timeout rises 64 cycles after tx_start, FSM returns to IDLE, and the next requester is granted. err_clr pulse clears it; err_clr in the same cycle as a timeout leaves it set.
- Async reset: assert rst_n low mid-WAIT_DONE, off-edge -> all outputs reset immediately. After release, a new packet from req2 is served normally.
